// File: rtl/alu_sequencer_if.sv
// Bundle between the ALU sequencer and its environment (imem, ALU, debug port).
// Latency: none, wires only.
// Backpressure: none; the ALU runs at a fixed latency and imem is combinational.
interface alu_sequencer_if #(
    parameter int PC_W = 8
) ();
    logic            start;
    logic            done;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] imem_addr;
    logic [8:0]      imem_data;
    logic [7:0]      alu_in1;
    logic [7:0]      alu_in2;
    logic [5:0]      alu_opcode;
    logic [7:0]      alu_result;
    logic            alu_overflow;
    logic            flag;
    logic [2:0]      dbg_addr;
    logic [7:0]      dbg_data;

    // Sequencer side
    modport master (
        input  start, imem_data, alu_result, alu_overflow, dbg_addr,
        output done, pc, imem_addr, alu_in1, alu_in2, alu_opcode, flag, dbg_data
    );

    // Environment side (imem, ALU, controller)
    modport slave (
        output start, imem_data, alu_result, alu_overflow, dbg_addr,
        input  done, pc, imem_addr, alu_in1, alu_in2, alu_opcode, flag, dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetch/decode 9-bit instructions, drive an external registered ALU, write back to 8x8 rf + flag.
// Latency: ALU instructions 3 cycles (FETCH, EXEC, WB), all others 2 cycles (FETCH, EXEC).
// Backpressure: none; ALU result is assumed valid exactly one cycle after issue, start ignored unless IDLE/HALTED.
module alu_sequencer #(
    parameter int PC_W = 8,
    parameter int NREG = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.master bus
);
    // A-type HALT encoding doubles as the ALU no-op presented outside EXEC
    localparam logic [5:0] OPC_IDLE = 6'b110_111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t                 r_state;
    logic [PC_W-1:0]        r_pc;
    logic [8:0]             r_ir;
    logic                   r_flag;
    logic                   r_done;
    logic [NREG-1:0][7:0]   r_rf;
    logic [7:0]             r_alu_in1;
    logic [7:0]             r_alu_in2;
    logic [5:0]             r_alu_opcode;

    logic [2:0]             w_op;
    logic [2:0]             w_func;
    logic [2:0]             w_r;
    logic [7:0]             w_rf_r;
    logic [7:0]             w_r0;
    logic [2:0]             w_f_op;
    logic [7:0]             w_f_rf_r;
    logic                   w_f_issue;
    logic                   w_issue;
    logic                   w_br_taken;
    logic [PC_W-1:0]        w_pc_inc;
    logic [PC_W-1:0]        w_br_tgt;

    // An instruction goes to the ALU for every R-type op and for the six real A-type functions
    function automatic logic f_is_alu(input logic [8:0] instr);
        logic res;
        res = 1'b0;
        case (instr[8:6])
            3'b010, 3'b011, 3'b100, 3'b101: res = 1'b1;
            3'b110:                         res = (instr[5:3] <= 3'b101);
            default:                        res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_op       = r_ir[8:6];
    assign w_func     = r_ir[5:3];
    assign w_r        = r_ir[2:0];
    assign w_rf_r     = r_rf[w_r];
    assign w_r0       = r_rf[0];
    assign w_issue    = f_is_alu(r_ir);

    assign w_f_op     = bus.imem_data[8:6];
    assign w_f_rf_r   = r_rf[bus.imem_data[2:0]];
    assign w_f_issue  = f_is_alu(bus.imem_data);

    assign w_pc_inc   = r_pc + PC_W'(1);
    // Branch offset is the signed register value, wrapped to the pc width
    assign w_br_tgt   = r_pc + PC_W'($signed(w_rf_r));
    assign w_br_taken = (w_op == 3'b111) &&
                        (((w_func == 3'b000) && !r_flag) || ((w_func == 3'b001) && r_flag));

    assign bus.pc         = r_pc;
    assign bus.imem_addr  = r_pc;
    assign bus.done       = r_done;
    assign bus.flag       = r_flag;
    assign bus.alu_in1    = r_alu_in1;
    assign bus.alu_in2    = r_alu_in2;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.dbg_data   = r_rf[bus.dbg_addr];

    // Control FSM with registered ALU drive, register file and flag; ALU drive is loaded in FETCH so it is valid during EXEC only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_flag       <= 1'b0;
            r_done       <= 1'b0;
            r_rf         <= '0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_opcode <= OPC_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pc    <= '0;
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_ir    <= bus.imem_data;
                    r_state <= S_EXEC;
                    if (w_f_issue) begin
                        r_alu_opcode <= bus.imem_data[8:3];
                        if (w_f_op == 3'b110) begin
                            r_alu_in1 <= 8'h00;
                            r_alu_in2 <= w_f_rf_r;
                        end else begin
                            r_alu_in1 <= w_f_rf_r;
                            r_alu_in2 <= w_r0;
                        end
                    end
                end

                S_EXEC: begin
                    r_alu_opcode <= OPC_IDLE;
                    r_alu_in1    <= 8'h00;
                    r_alu_in2    <= 8'h00;
                    if (w_issue) begin
                        r_state <= S_WB;
                    end else begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                        case (w_op)
                            3'b000: r_rf[0] <= {2'b00, r_ir[5:0]};
                            3'b001: begin
                                if (w_func == 3'b000) begin
                                    r_rf[w_r] <= w_r0;
                                end else if (w_func == 3'b001) begin
                                    r_rf[0] <= w_rf_r;
                                end
                            end
                            3'b110: begin
                                // only NOP and HALT reach here; HALT freezes pc
                                if (w_func == 3'b111) begin
                                    r_pc    <= r_pc;
                                    r_done  <= 1'b1;
                                    r_state <= S_HALTED;
                                end
                            end
                            3'b111: begin
                                if (w_br_taken) begin
                                    r_pc <= w_br_tgt;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_WB: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                    case (w_op)
                        3'b010: begin
                            r_rf[0] <= bus.alu_result;
                            r_flag  <= bus.alu_overflow;
                        end
                        3'b011, 3'b100: r_flag  <= bus.alu_overflow;
                        3'b101:         r_rf[0] <= bus.alu_result;
                        3'b110: begin
                            // LSL/LSR/INCR/ZERO update the register; LSL/AND1/EQZ update the flag
                            if (w_func <= 3'b011) begin
                                r_rf[w_r] <= bus.alu_result;
                            end
                            if ((w_func == 3'b000) || (w_func == 3'b100) || (w_func == 3'b101)) begin
                                r_flag <= bus.alu_overflow;
                            end
                        end
                        default: ;
                    endcase
                end

                S_HALTED: begin
                    if (bus.start) begin
                        r_pc    <= '0;
                        r_done  <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models imem and a registered ALU, predicts pc trace and ALU issues with an instruction-level model.
// Latency: checks per-cycle pc and the single-cycle ALU issue window against the predicted trace.
// Backpressure: n/a; start pulses are also injected mid-program and must be ignored.
module tb_alu_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.PC_W(8)) bus ();

    alu_sequencer #(.PC_W(8), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0]  imem [256];
    logic [7:0]  alu_res_q;
    logic        alu_ov_q;

    logic [7:0]  m_rf [8];
    logic        m_flag;
    logic [7:0]  m_pc;
    logic [7:0]  q_pc [$];
    logic [21:0] q_alu [$];

    // Reference ALU: returns {overflow, result}
    function automatic logic [8:0] alu_fn(input logic [5:0] opc, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = 9'h000;
        case (opc[5:3])
            3'b010: r = {1'b0, a} + {1'b0, b};
            3'b011: r = {(a == b), 8'h00};
            3'b100: r = {(a < b), 8'h00};
            3'b101: r = {1'b0, ((a >= b) ? (a - b) : (b - a))};
            3'b110: begin
                case (opc[2:0])
                    3'b000: r = {b[7], b[6:0], 1'b0};
                    3'b001: r = {b[0], 1'b0, b[7:1]};
                    3'b010: r = {1'b0, b + 8'd1};
                    3'b011: r = 9'h000;
                    3'b100: r = {b[0], 8'h00};
                    3'b101: r = {(b == 8'h00), 8'h00};
                    default: r = 9'h000;
                endcase
            end
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign bus.imem_data    = imem[bus.imem_addr];
    assign bus.alu_result   = alu_res_q;
    assign bus.alu_overflow = alu_ov_q;

    always @(posedge clk) begin
        {alu_ov_q, alu_res_q} <= alu_fn(bus.alu_opcode, bus.alu_in1, bus.alu_in2);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic load_prog(input logic [8:0] p[$]);
        for (int i = 0; i < 256; i++) imem[i] = 9'h1B8;
        for (int i = 0; i < p.size(); i++) imem[i] = p[i];
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), {24'h0, bus.dbg_data}, {24'h0, m_rf[i]});
        end
    endtask

    task automatic read_reg(input int a, output logic [7:0] d);
        bus.dbg_addr = 3'(a);
        #1;
        d = bus.dbg_data;
    endtask

    // Instruction-level model: fills the pc trace (one entry per cycle) and the ALU issue queue
    task automatic model_run();
        logic [7:0] pc;
        logic [8:0] instr;
        logic [2:0] op, fn, r;
        logic [7:0] a, b, res;
        logic       ov;
        pc = 8'h00;
        for (int step = 0; step < 64; step++) begin
            instr = imem[pc];
            op = instr[8:6]; fn = instr[5:3]; r = instr[2:0];
            if ((op >= 3'd2 && op <= 3'd5) || (op == 3'd6 && fn <= 3'd5)) begin
                a = (op == 3'd6) ? 8'h00 : m_rf[r];
                b = (op == 3'd6) ? m_rf[r] : m_rf[0];
                q_alu.push_back({instr[8:3], a, b});
                {ov, res} = alu_fn(instr[8:3], a, b);
                repeat (3) q_pc.push_back(pc);
                case (op)
                    3'd2: begin m_rf[0] = res; m_flag = ov; end
                    3'd3, 3'd4: m_flag = ov;
                    3'd5: m_rf[0] = res;
                    default: begin
                        if (fn <= 3'd3) m_rf[r] = res;
                        if (fn == 3'd0 || fn == 3'd4 || fn == 3'd5) m_flag = ov;
                    end
                endcase
                pc = pc + 8'd1;
            end else begin
                repeat (2) q_pc.push_back(pc);
                if (op == 3'd6 && fn == 3'd7) begin
                    m_pc = pc;
                    return;
                end
                if (op == 3'd0) m_rf[0] = {2'b00, instr[5:0]};
                if (op == 3'd1 && fn == 3'd0) m_rf[r] = m_rf[0];
                if (op == 3'd1 && fn == 3'd1) m_rf[0] = m_rf[r];
                if (op == 3'd7 && ((fn == 3'd0 && !m_flag) || (fn == 3'd1 && m_flag)))
                    pc = pc + m_rf[r];
                else
                    pc = pc + 8'd1;
            end
        end
        m_pc = pc;
    endtask

    // Start the loaded program and score every cycle until done; glitch >= 0 injects a stray start pulse
    task automatic run_prog(input string tag, input int glitch, output int lat);
        int          cyc;
        int          exp_len;
        logic [7:0]  ep;
        logic [21:0] e;
        q_pc.delete();
        q_alu.delete();
        model_run();
        exp_len = q_pc.size();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 300) begin
            bus.start = (cyc == glitch);
            if (q_pc.size() > 0) begin
                ep = q_pc.pop_front();
                check({tag, "_pc"}, {24'h0, bus.pc}, {24'h0, ep});
                check({tag, "_imem_addr"}, {24'h0, bus.imem_addr}, {24'h0, ep});
            end
            if (bus.alu_opcode !== 6'b110_111) begin
                e = (q_alu.size() > 0) ? q_alu.pop_front() : 22'h3FFFFF;
                check({tag, "_alu_issue"}, {10'h0, bus.alu_opcode, bus.alu_in1, bus.alu_in2}, {10'h0, e});
            end else begin
                check({tag, "_alu_idle_ops"}, {16'h0, bus.alu_in1, bus.alu_in2}, 32'h0);
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        lat = cyc;
        check({tag, "_done"}, {31'h0, bus.done}, 32'h1);
        check({tag, "_latency"}, cyc, exp_len);
        check({tag, "_alu_left"}, q_alu.size(), 0);
        check({tag, "_final_pc"}, {24'h0, bus.pc}, {24'h0, m_pc});
        check({tag, "_flag"}, {31'h0, bus.flag}, {31'h0, m_flag});
        check_rf(tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] prog [$];
        logic [7:0] d;
        int         lat;
        bit         found;

        bus.start    = 1'b0;
        bus.dbg_addr = 3'd0;
        for (int i = 0; i < 256; i++) imem[i] = 9'h1B8;
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_flag = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_pc", {24'h0, bus.pc}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_flag", {31'h0, bus.flag}, 32'h0);
        check("rst_opcode", {26'h0, bus.alu_opcode}, 32'h37);
        check("rst_ops", {16'h0, bus.alu_in1, bus.alu_in2}, 32'h0);
        check_rf("rst");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_pc", {24'h0, bus.pc}, 32'h0);
        check("idle_done", {31'h0, bus.done}, 32'h0);

        // Program 1, with a stray start while running
        prog = '{9'h005, 9'h043, 9'h03C, 9'h083, 9'h1B8};
        load_prog(prog);
        run_prog("p1", 3, lat);
        check("p1_done_after_11", lat, 11);
        read_reg(0, d); check("p1_r0_const", {24'h0, d}, 32'h41);
        read_reg(3, d); check("p1_r3_const", {24'h0, d}, 32'h05);
        check("p1_pc_const", {24'h0, bus.pc}, 32'h4);

        // Program 2: shifts then carry-out ADD, restarted from HALTED
        prog = '{9'h032, 9'h180, 9'h180, 9'h041, 9'h081, 9'h1B8};
        load_prog(prog);
        run_prog("p2", -1, lat);
        read_reg(0, d); check("p2_r0_const", {24'h0, d}, 32'h90);
        read_reg(1, d); check("p2_r1_const", {24'h0, d}, 32'hC8);
        read_reg(3, d); check("p2_r3_kept", {24'h0, d}, 32'h05);
        check("p2_flag_const", {31'h0, bus.flag}, 32'h1);

        // DIST leaves the flag alone
        prog = '{9'h03C, 9'h041, 9'h005, 9'h141, 9'h1B8};
        load_prog(prog);
        run_prog("dist", 2, lat);
        read_reg(0, d); check("dist_r0_const", {24'h0, d}, 32'h37);
        check("dist_flag_kept", {31'h0, bus.flag}, 32'h1);

        // Mixed: LT, INCR, MATCH, EQZ, LSR, ZERO, MOV R0<-Rr, A-type NOP
        prog = '{9'h007, 9'h044, 9'h009, 9'h104, 9'h194, 9'h0C4, 9'h1AD, 9'h18C,
                 9'h198, 9'h04C, 9'h1B0, 9'h1B8};
        load_prog(prog);
        run_prog("mix", -1, lat);
        read_reg(4, d); check("mix_r4_const", {24'h0, d}, 32'h04);

        // BOF taken backwards from pc 10 to pc 6
        prog = '{9'h005, 9'h041, 9'h03F, 9'h180, 9'h180, 9'h042, 9'h1C9, 9'h082,
                 9'h1D0, 9'h1D0, 9'h1CA, 9'h1B8};
        load_prog(prog);
        run_prog("bof", -1, lat);
        read_reg(2, d); check("bof_r2_const", {24'h0, d}, 32'hFC);
        check("bof_pc_const", {24'h0, bus.pc}, 32'd11);

        // BNO not taken at pc 10 with flag set
        prog = '{9'h005, 9'h041, 9'h03F, 9'h180, 9'h180, 9'h042, 9'h1C9, 9'h082,
                 9'h1D0, 9'h1D0, 9'h1C2, 9'h1B8};
        load_prog(prog);
        run_prog("bno", -1, lat);
        check("bno_pc_const", {24'h0, bus.pc}, 32'd11);

        // Reset while the ADD is in EXEC
        prog = '{9'h005, 9'h043, 9'h03C, 9'h083, 9'h1B8};
        load_prog(prog);
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (bus.alu_opcode === 6'b010_000) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_add_seen", {31'h0, found}, 32'h1);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_flag = 1'b0;
        check("rst_exec_pc", {24'h0, bus.pc}, 32'h0);
        check("rst_exec_flag", {31'h0, bus.flag}, 32'h0);
        check("rst_exec_done", {31'h0, bus.done}, 32'h0);
        check("rst_exec_opcode", {26'h0, bus.alu_opcode}, 32'h37);
        check("rst_exec_ops", {16'h0, bus.alu_in1, bus.alu_in2}, 32'h0);
        check_rf("rst_exec");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_pc", {24'h0, bus.pc}, 32'h0);
        check("post_rst_done", {31'h0, bus.done}, 32'h0);
        check_rf("post_rst");

        // Normal operation again after the aborted run
        run_prog("p1b", -1, lat);
        check("p1b_done_after_11", lat, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit that drives the 8-bit ALU as its initiator.
- Fetches 9-bit instructions from an asynchronous instruction ROM and decodes them.
- Issues operands and the 6-bit opcode to the registered ALU, waits for the result, then writes back to an internal 8x8 register file and a 1-bit flag.
- Resolves BNO/BOF branches from that flag and stops on HALT.

Parameters:
PC_W, 8, program counter / imem address width; wraps modulo 2^PC_W
NREG, 8, register file depth; fixed by the 3-bit reg field

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; honoured only in IDLE or HALTED
done  out  1  high while in HALTED
pc  out  PC_W  current program counter
imem_addr  out  PC_W  equals pc
imem_data  in  9  instruction at imem_addr, combinational
alu_in1  out  8  ALU operand 1
alu_in2  out  8  ALU operand 2
alu_opcode  out  6  {op[2:0], func[2:0]}
alu_result  in  8  ALU result, valid the cycle after issue
alu_overflow  in  1  ALU flag output, valid the cycle after issue
flag  out  1  architectural flag register
dbg_addr  in  3  register file read address for observation
dbg_data  out  8  rf[dbg_addr], combinational

Behaviour:
- Instruction fields: op = instr[8:6], func = instr[5:3], r = instr[2:0]. R0 is the accumulator.
- Reset values: pc=0, flag=0, all rf=0, done=0, state IDLE, alu_in1=alu_in2=0, alu_opcode=6'b110_111.
- Outside EXEC, alu_opcode is held at 6'b110_111 (A-type HALT, an ALU no-op) and operands are held at 0.
- States:
  - IDLE: start -> FETCH with pc=0.
  - FETCH: latch imem_data into ir -> EXEC.
  - EXEC, non-ALU instruction: completes in this cycle, pc+1 (or branch target) -> FETCH.
  - EXEC, HALT: -> HALTED, pc unchanged.
  - EXEC, ALU instruction: drives alu_* for exactly this one cycle -> WB.
  - WB: sample alu_result / alu_overflow, write back, pc+1 -> FETCH.
  - HALTED: done=1; start -> FETCH with pc=0, rf and flag retained.
- Latency: ALU instructions take 3 cycles; all others take 2.
- Instruction set:
  - op 000 LDI: R0 <- {2'b0, instr[5:0]}.
  - op 001 MOV: func 000 gives rf[r] <- R0; func 001 gives R0 <- rf[r]; other func values are NOP.
  - op 010 ADD / 011 MATCH / 100 LT / 101 DIST: in1=rf[r], in2=R0. ADD and DIST write R0. ADD, MATCH and LT write flag.
  - op 110 A-type: in2=rf[r], in1=0.
    - LSL, LSR, INCR and ZERO write rf[r].
    - LSL, AND1 and EQZ write flag.
    - func 110 is NOP; it is not issued to the ALU.
    - func 111 HALT is not issued to the ALU.
  - op 111 B-type: func 000 BNO is taken when flag==0; func 001 BOF is taken when flag==1; other func values are NOP.
    - Taken: pc <- pc + sign-extended rf[r], truncated to PC_W.
    - Not taken: pc <- pc+1. Not issued to the ALU.
- Flag is unchanged by every instruction not listed as writing it.
- pc increment and branch targets wrap modulo 2^PC_W.
- Writes to R0 via rf[r] with r=0 are legal; the last write wins, and there is only one write per instruction.
- start outside IDLE/HALTED is ignored.
- reset in any state, including EXEC/WB, aborts immediately: no writeback, all reset values restored.

Test Plan:
- Prog {9'h005 LDI 5, 9'h043 MOV R3<-R0, 9'h03C LDI 60, 9'h083 ADD R3, 9'h1B8 HALT}, start -> R0=0x41, R3=0x05, flag=0, done high 11 cycles after start, pc=4.
- LDI 50, LSL R0 x2 (9'h180), MOV R1<-R0, ADD R1 -> R0=0xC8 after the shifts, then R0=0x90, flag=1.
- flag=1, R2=0xFC (LDI 63, LSL R0 x2, MOV R2), BOF R2 (9'h1CA) at pc=10 -> next fetch at pc=6. BNO R2 at pc=10 -> pc=11.
- Check alu_opcode=6'b010_000 and alu_in1/in2 only during the single ADD EXEC cycle; alu_opcode=6'b110_111 otherwise. DIST with R1=60, R0=5 -> R0=55, flag unchanged.
- Assert reset during ADD EXEC -> same cycle: pc=0, flag=0, dbg_data=0 for all addresses, done=0, alu_opcode=6'b110_111; no writeback afterwards.
- start pulsed mid-program -> ignored, pc sequence unchanged. start in HALTED -> restarts at pc=0 with rf preserved.
